// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch side (ic_*), load/store side (dc_*)
// and the shared backing-memory port (mem_*).
// slave  : the arbiter's view
// master : the view of the requesters and the memory model around it
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // fetch requester
  logic                  ic_req_i;
  logic [ADDR_WIDTH-1:0] ic_addr_i;
  logic                  ic_gnt_o;
  logic                  ic_rvalid_o;
  logic [DATA_WIDTH-1:0] ic_rdata_o;
  // load/store requester
  logic                  dc_req_i;
  logic                  dc_we_i;
  logic [1:0]            dc_size_i;
  logic [ADDR_WIDTH-1:0] dc_addr_i;
  logic [DATA_WIDTH-1:0] dc_wdata_i;
  logic                  dc_gnt_o;
  logic                  dc_rvalid_o;
  logic [DATA_WIDTH-1:0] dc_rdata_o;
  // backing memory
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [1:0]            mem_size_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ready_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  ic_req_i, ic_addr_i,
    output ic_gnt_o, ic_rvalid_o, ic_rdata_o,
    input  dc_req_i, dc_we_i, dc_size_i, dc_addr_i, dc_wdata_i,
    output dc_gnt_o, dc_rvalid_o, dc_rdata_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output ic_req_i, ic_addr_i,
    input  ic_gnt_o, ic_rvalid_o, ic_rdata_o,
    output dc_req_i, dc_we_i, dc_size_i, dc_addr_i, dc_wdata_i,
    input  dc_gnt_o, dc_rvalid_o, dc_rdata_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the fetch (ic)
// and load/store (dc) requesters. One transaction in flight at a time:
// IDLE (grant + capture) -> BUSY (hold mem_req until ready) -> RESP (rvalid).
// dc has priority; after STARVE_LIMIT consecutive dc grants with ic waiting,
// ic is granted next.
// Optional build macro MEM_ARB_PERF_EN adds saturating grant/stall counters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mem_port_arbiter_if.slave     bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           ic_grant_cnt_o,
  output logic [31:0]           dc_grant_cnt_o,
  output logic [31:0]           stall_cycles_o
`endif
);

  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int         SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic                  owner_ic;
    logic                  we;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state_q, state_d;
  req_t                  cap_q, cap_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  ic_gnt, dc_gnt;
  logic                  starve_hit;
  logic [DATA_WIDTH-1:0] ic_rdata_q, dc_rdata_q;

  assign starve_hit = (starve_q == STARVE_MAX);

  // State, captured request and starvation counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration, capture and FSM sequencing
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    starve_d = starve_q;
    ic_gnt   = 1'b0;
    dc_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        // a fetch that is no longer waiting has nothing to be starved of
        if (!bus.ic_req_i) starve_d = '0;
        if (bus.ic_req_i && (!bus.dc_req_i || starve_hit)) begin
          ic_gnt         = 1'b1;
          cap_d.owner_ic = 1'b1;
          cap_d.we       = 1'b0;
          cap_d.size     = SIZE_WORD;
          cap_d.addr     = bus.ic_addr_i;
          cap_d.wdata    = '0;
          starve_d       = '0;
          state_d        = BUSY;
        end else if (bus.dc_req_i) begin
          dc_gnt         = 1'b1;
          cap_d.owner_ic = 1'b0;
          cap_d.we       = bus.dc_we_i;
          cap_d.size     = bus.dc_size_i;
          cap_d.addr     = bus.dc_addr_i;
          cap_d.wdata    = bus.dc_wdata_i;
          if (bus.ic_req_i && !starve_hit) starve_d = starve_q + 1'b1;
          state_d        = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready_i) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-side read data: loaded on memory completion, held otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else if (state_q == BUSY && bus.mem_ready_i) begin
      if (cap_q.owner_ic) ic_rdata_q <= bus.mem_rdata_i;
      else                dc_rdata_q <= cap_q.we ? '0 : bus.mem_rdata_i;
    end
  end

  assign bus.ic_gnt_o    = ic_gnt;
  assign bus.dc_gnt_o    = dc_gnt;
  assign bus.ic_rvalid_o = (state_q == RESP) &&  cap_q.owner_ic;
  assign bus.dc_rvalid_o = (state_q == RESP) && !cap_q.owner_ic;
  assign bus.ic_rdata_o  = ic_rdata_q;
  assign bus.dc_rdata_o  = dc_rdata_q;

  // mem_req derives straight from state so an async reset drops it at once
  assign bus.mem_req_o   = (state_q == BUSY);
  assign bus.mem_we_o    = cap_q.we;
  assign bus.mem_size_o  = cap_q.size;
  assign bus.mem_addr_o  = cap_q.addr;
  assign bus.mem_wdata_o = cap_q.wdata;

`ifdef MEM_ARB_PERF_EN
  logic stall_now;
  assign stall_now = (bus.ic_req_i & ~ic_gnt) | (bus.dc_req_i & ~dc_gnt);

  // Saturating grant and stall counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_grant_cnt_o <= '0;
      dc_grant_cnt_o <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (ic_gnt    && ic_grant_cnt_o != '1) ic_grant_cnt_o <= ic_grant_cnt_o + 32'd1;
      if (dc_gnt    && dc_grant_cnt_o != '1) dc_grant_cnt_o <= dc_grant_cnt_o + 32'd1;
      if (stall_now && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
